// File: rtl/ddr2_ctrl_fsm_pkg.sv
// rtl/ddr2_ctrl_fsm_pkg.sv - shared types and constants for the DDR2 closed-page sequencer
package ddr2_ctrl_fsm_pkg;

    typedef logic       ulogic1;
    typedef logic [1:0] ulogic2;
    typedef logic [2:0] state_t;

    // Values are the raw {cs_n, ras_n, cas_n, we_n} bus encodings
    typedef enum logic [3:0] {
        CMD_ACT = 4'b0011,
        CMD_RD  = 4'b0101,
        CMD_WR  = 4'b0100,
        CMD_PRE = 4'b0010,
        CMD_NOP = 4'b0111
    } cmd_t;

    localparam state_t ST_INIT = 3'd0;
    localparam state_t ST_IDLE = 3'd1;
    localparam state_t ST_ACT  = 3'd2;
    localparam state_t ST_RCD  = 3'd3;
    localparam state_t ST_CAS  = 3'd4;
    localparam state_t ST_DATA = 3'd5;
    localparam state_t ST_PRE  = 3'd6;
    localparam state_t ST_RP   = 3'd7;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ddr2_cmd_drv.sv
// rtl/ddr2_cmd_drv.sv - registers the next command and expands it onto the DDR2 command bus
module ddr2_cmd_drv
    import ddr2_ctrl_fsm_pkg::*;
#(
    parameter int ROW_WIDTH = 13
) (
    input  logic                 ck,
    input  logic                 reset,
    input  cmd_t                 cmd,
    input  ulogic2               cmd_ba,
    input  logic [ROW_WIDTH-1:0] cmd_addr,
    output logic                 cs_n,
    output logic                 ras_n,
    output logic                 cas_n,
    output logic                 we_n,
    output ulogic2               ba,
    output logic [ROW_WIDTH-1:0] addr
);

    cmd_t cmd_q;

    always_ff @(posedge ck) begin
        if (reset) begin
            cmd_q <= CMD_NOP;
            ba    <= '0;
            addr  <= '0;
        end else begin
            cmd_q <= cmd;
            ba    <= cmd_ba;
            addr  <= cmd_addr;
        end
    end

    assign {cs_n, ras_n, cas_n, we_n} = cmd_q;

endmodule

// File: rtl/ddr2_ctrl_fsm.sv
// rtl/ddr2_ctrl_fsm.sv - closed-page DDR2 sequencer: ACTIVATE, READ/WRITE, PRECHARGE per request
module ddr2_ctrl_fsm
    import ddr2_ctrl_fsm_pkg::*;
#(
    parameter int ROW_WIDTH  = 13,
    parameter int COL_WIDTH  = 10,
    parameter int DATA_WIDTH = 16,
    parameter int T_INIT     = 8,
    parameter int T_RCD      = 3,
    parameter int CL         = 4,
    parameter int T_RP       = 3
) (
    input  logic                            ck,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_we,
    input  logic [2+ROW_WIDTH+COL_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    output logic                            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            cke,
    output logic                            cs_n,
    output logic                            ras_n,
    output logic                            cas_n,
    output logic                            we_n,
    output logic [1:0]                      ba,
    output logic [ROW_WIDTH-1:0]            addr,
    output logic [DATA_WIDTH-1:0]           dq_out,
    output logic                            dq_oe,
    input  logic [DATA_WIDTH-1:0]           dq_in,
    output logic                            busy
);

    localparam int CNT_MAX = max4(T_INIT, T_RCD, CL, T_RP);
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t                 state, next_state;
    logic [CW-1:0]          cnt, next_cnt;
    ulogic1                 we_q;
    ulogic2                 ba_q;
    logic [COL_WIDTH-1:0]   col_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic                   accept;
    logic                   launch;
    logic                   capture;
    cmd_t                   cmd_d;
    ulogic2                 ba_d;
    logic [ROW_WIDTH-1:0]   addr_d;
    ulogic2                 req_ba;
    logic [ROW_WIDTH-1:0]   req_row;
    logic [COL_WIDTH-1:0]   req_col;

    assign req_ba  = req_addr[ROW_WIDTH+COL_WIDTH +: 2];
    assign req_row = req_addr[COL_WIDTH +: ROW_WIDTH];
    assign req_col = req_addr[COL_WIDTH-1:0];
    assign accept  = req_valid && req_ready;

    // Wait states hold for reload+1 cycles; RP holds T_RP cycles so a
    // request period is 3+T_RCD+CL+T_RP including the IDLE handshake cycle.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            ST_INIT: begin
                if (cnt == '0) next_state = ST_IDLE;
                else           next_cnt   = cnt - CW'(1);
            end
            ST_IDLE: begin
                if (accept) next_state = ST_ACT;
            end
            ST_ACT: begin
                if (T_RCD > 1) begin
                    next_state = ST_RCD;
                    next_cnt   = CW'(T_RCD - 2);
                end else begin
                    next_state = ST_CAS;
                end
            end
            ST_RCD: begin
                if (cnt == '0) next_state = ST_CAS;
                else           next_cnt   = cnt - CW'(1);
            end
            ST_CAS: begin
                next_state = ST_DATA;
                next_cnt   = CW'(CL - 1);
            end
            ST_DATA: begin
                if (cnt == '0) next_state = ST_PRE;
                else           next_cnt   = cnt - CW'(1);
            end
            ST_PRE: begin
                next_state = ST_RP;
                next_cnt   = CW'(T_RP - 1);
            end
            ST_RP: begin
                if (cnt == '0) next_state = ST_IDLE;
                else           next_cnt   = cnt - CW'(1);
            end
            default: begin
                next_state = ST_INIT;
                next_cnt   = CW'(T_INIT);
            end
        endcase
    end

    // Commands are chosen from the state being entered so the registered bus lines up with state
    always_comb begin
        cmd_d  = CMD_NOP;
        ba_d   = '0;
        addr_d = '0;
        case (next_state)
            ST_ACT: begin
                cmd_d  = CMD_ACT;
                ba_d   = req_ba;
                addr_d = req_row;
            end
            ST_CAS: begin
                cmd_d  = we_q ? CMD_WR : CMD_RD;
                ba_d   = ba_q;
                addr_d = ROW_WIDTH'(col_q);
            end
            ST_PRE: begin
                cmd_d  = CMD_PRE;
                ba_d   = ba_q;
            end
            default: ;
        endcase
    end

    // Write data sits on the bus during the last DATA cycle; read data is taken as PRE retires
    assign launch  = (next_state == ST_DATA) && (next_cnt == '0) && we_q;
    assign capture = (state == ST_PRE) && !we_q;

    always_ff @(posedge ck) begin
        if (reset) begin
            state     <= ST_INIT;
            cnt       <= CW'(T_INIT);
            we_q      <= 1'b0;
            ba_q      <= '0;
            col_q     <= '0;
            wdata_q   <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            cke       <= 1'b0;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else begin
            state     <= next_state;
            cnt       <= next_cnt;
            if (accept) begin
                we_q    <= req_we;
                ba_q    <= req_ba;
                col_q   <= req_col;
                wdata_q <= req_wdata;
            end
            req_ready <= (next_state == ST_IDLE);
            busy      <= (next_state != ST_IDLE);
            cke       <= !((next_state == ST_INIT) && (next_cnt != '0));
            dq_oe     <= launch;
            dq_out    <= launch ? wdata_q : '0;
            rd_valid  <= capture;
            if (capture) rd_data <= dq_in;
        end
    end

    ddr2_cmd_drv #(
        .ROW_WIDTH (ROW_WIDTH)
    ) u_cmd_drv (
        .ck       (ck),
        .reset    (reset),
        .cmd      (cmd_d),
        .cmd_ba   (ba_d),
        .cmd_addr (addr_d),
        .cs_n     (cs_n),
        .ras_n    (ras_n),
        .cas_n    (cas_n),
        .we_n     (we_n),
        .ba       (ba),
        .addr     (addr)
    );

endmodule

// File: tb/tb_ddr2_ctrl_fsm.sv
// tb/tb_ddr2_ctrl_fsm.sv - directed table-driven bench for ddr2_ctrl_fsm with a small DRAM model
module tb_ddr2_ctrl_fsm;

    localparam int CL = 4;
    localparam logic [3:0] B_ACT = 4'b0011;
    localparam logic [3:0] B_RD  = 4'b0101;
    localparam logic [3:0] B_WR  = 4'b0100;
    localparam logic [3:0] B_PRE = 4'b0010;
    localparam logic [3:0] B_NOP = 4'b0111;
    localparam logic [24:0] A1 = {2'd1, 13'h0123, 10'h045};
    localparam logic [24:0] A2 = {2'd2, 13'h01A5, 10'h002};
    localparam logic [24:0] A3 = {2'd0, 13'h0005, 10'h077};

    logic        ck = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [24:0] req_addr;
    logic [15:0] req_wdata;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] addr;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [15:0] dq_bus;
    logic        busy;

    ddr2_ctrl_fsm dut (
        .ck        (ck),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .cke       (cke),
        .cs_n      (cs_n),
        .ras_n     (ras_n),
        .cas_n     (cas_n),
        .we_n      (we_n),
        .ba        (ba),
        .addr      (addr),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .dq_in     (dq_bus),
        .busy      (busy)
    );

    always #5 ck = ~ck;

    // DRAM model: data edge is CL edges after the READ/WRITE command edge
    logic [15:0] mem [0:1023];
    logic        dram_oe = 1'b0;
    logic [15:0] dram_q = '0;
    int          rd_cnt = 0, wr_cnt = 0, conflicts = 0;
    logic [9:0]  rcol = '0, wcol = '0;

    always_comb dq_bus = dq_oe ? dq_out : (dram_oe ? dram_q : 16'h0000);

    always @(posedge ck) begin
        dram_oe <= 1'b0;
        if (dq_oe && dram_oe) conflicts++;
        if (!cke) begin
            rd_cnt = 0;
            wr_cnt = 0;
        end else begin
            if (wr_cnt > 0) begin
                wr_cnt--;
                if (wr_cnt == 0) mem[wcol] = dq_bus;
            end
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    dram_oe <= 1'b1;
                    dram_q  <= mem[rcol];
                end
            end
            case ({cs_n, ras_n, cas_n, we_n})
                B_RD: begin rd_cnt = CL; rcol = addr[9:0]; end
                B_WR: begin wr_cnt = CL; wcol = addr[9:0]; end
                default: ;
            endcase
        end
    end

    typedef struct {
        logic        valid;
        logic        we;
        logic [24:0] a;
        logic [15:0] wd;
        logic [3:0]  bus;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        oe;
        logic [15:0] dout;
        logic        rv;
        logic [15:0] rdata;
        logic        ready;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic v, input logic w, input logic [24:0] a,
                                input logic [15:0] wd, input logic [3:0] bus, input logic [1:0] b,
                                input logic [12:0] ad, input logic oe, input logic [15:0] dout,
                                input logic rv, input logic [15:0] rdat, input logic rdy);
        vec_t r;
        r.valid = v;  r.we = w;     r.a = a;       r.wd = wd;
        r.bus = bus;  r.ba = b;     r.addr = ad;   r.oe = oe;
        r.dout = dout; r.rv = rv;   r.rdata = rdat; r.ready = rdy;
        return r;
    endfunction

    task automatic push_nops(input int n);
        for (int i = 0; i < n; i++)
            vecs.push_back(mk(1'b0, 1'b0, '0, '0, B_NOP, 2'd0, '0, 1'b0, '0, 1'b0, '0, 1'b0));
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at the negedge right after the last reset edge; leaves in the first IDLE cycle
    task automatic init_seq(input string tag);
        check({tag, "_rst_vals"}, {cke, cs_n, ras_n, cas_n, we_n, req_ready, busy, dq_oe, rd_valid},
              {1'b0, B_NOP, 1'b0, 1'b1, 1'b0, 1'b0});
        check({tag, "_rst_data"}, {ba, addr, dq_out, rd_data}, '0);
        reset = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            check($sformatf("%s_init_c%0d", tag, c),
                  {cke, cs_n, ras_n, cas_n, we_n, req_ready, busy, dq_oe, rd_valid},
                  {(c >= 9), B_NOP, (c == 10), (c != 10), 1'b0, 1'b0});
            if (c < 10) begin
                @(posedge ck);
                @(negedge ck);
            end
        end
    endtask

    initial begin
        vec_t v;
        int   t_acc1, t_acc2, t_rv, rv_count;
        logic [15:0] rv_data;

        for (int i = 0; i < 1024; i++) mem[i] = '0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_addr = '0;
        req_wdata = '0;

        // Write 0xBEEF to A1, then read it back
        vecs.push_back(mk(1'b1, 1'b1, A1, 16'hBEEF, B_NOP, 2'd0, '0, 1'b0, '0, 1'b0, '0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, '0, '0, B_ACT, 2'd1, 13'h0123, 1'b0, '0, 1'b0, '0, 1'b0));
        push_nops(2);
        vecs.push_back(mk(1'b0, 1'b0, '0, '0, B_WR, 2'd1, 13'h0045, 1'b0, '0, 1'b0, '0, 1'b0));
        push_nops(3);
        vecs.push_back(mk(1'b0, 1'b0, '0, '0, B_NOP, 2'd0, '0, 1'b1, 16'hBEEF, 1'b0, '0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, '0, '0, B_PRE, 2'd1, '0, 1'b0, '0, 1'b0, '0, 1'b0));
        push_nops(3);
        vecs.push_back(mk(1'b1, 1'b0, A1, '0, B_NOP, 2'd0, '0, 1'b0, '0, 1'b0, '0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, '0, '0, B_ACT, 2'd1, 13'h0123, 1'b0, '0, 1'b0, '0, 1'b0));
        push_nops(2);
        vecs.push_back(mk(1'b0, 1'b0, '0, '0, B_RD, 2'd1, 13'h0045, 1'b0, '0, 1'b0, '0, 1'b0));
        push_nops(4);
        vecs.push_back(mk(1'b0, 1'b0, '0, '0, B_PRE, 2'd1, '0, 1'b0, '0, 1'b0, '0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, '0, '0, B_NOP, 2'd0, '0, 1'b0, '0, 1'b1, 16'hBEEF, 1'b0));
        push_nops(2);
        vecs.push_back(mk(1'b0, 1'b0, '0, '0, B_NOP, 2'd0, '0, 1'b0, '0, 1'b0, '0, 1'b1));

        repeat (3) @(posedge ck);
        @(negedge ck);
        init_seq("por");

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            req_valid = v.valid;
            req_we    = v.we;
            req_addr  = v.a;
            req_wdata = v.wd;
            check($sformatf("row%0d_bus", i), {cs_n, ras_n, cas_n, we_n}, v.bus);
            if (v.bus == B_PRE)
                check($sformatf("row%0d_pre_ba_a10", i), {ba, addr[10]}, {v.ba, 1'b0});
            else if (v.bus != B_NOP)
                check($sformatf("row%0d_ba_addr", i), {ba, addr}, {v.ba, v.addr});
            check($sformatf("row%0d_dq_oe", i), dq_oe, v.oe);
            if (v.oe) check($sformatf("row%0d_dq_out", i), dq_out, v.dout);
            check($sformatf("row%0d_rd_valid", i), rd_valid, v.rv);
            if (v.rv) check($sformatf("row%0d_rd_data", i), rd_data, v.rdata);
            check($sformatf("row%0d_ready_busy", i), {req_ready, busy}, {v.ready, !v.ready});
            @(posedge ck);
            @(negedge ck);
        end
        check("mem_045", mem[10'h045], 16'hBEEF);

        // Back-to-back write then read with req_valid held high throughout
        t_acc1 = -1; t_acc2 = -1; t_rv = -1; rv_count = 0; rv_data = '0;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = A2;
        req_wdata = 16'h1111;
        for (int c = 0; c < 40; c++) begin
            if (req_ready && req_valid) begin
                if (t_acc1 < 0)      t_acc1 = c;
                else if (t_acc2 < 0) t_acc2 = c;
            end
            if (rd_valid) begin
                rv_count++;
                rv_data = rd_data;
                t_rv = c;
            end
            @(posedge ck);
            @(negedge ck);
            if (t_acc2 >= 0)      req_valid = 1'b0;
            else if (t_acc1 >= 0) req_we = 1'b0;
        end
        check("b2b_accept_gap", 64'(t_acc2 - t_acc1), 64'd13);
        check("b2b_rd_latency", 64'(t_rv - t_acc2), 64'd10);
        check("b2b_rv_pulses", 64'(rv_count), 64'd1);
        check("b2b_rd_data", rv_data, 16'h1111);
        check("mem_002", mem[10'h002], 16'h1111);

        // Reset during the DATA phase of a write
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = A3;
        req_wdata = 16'hCAFE;
        check("mr_ready", req_ready, 1'b1);
        @(posedge ck);
        @(negedge ck);
        req_valid = 1'b0;
        repeat (5) begin
            @(posedge ck);
            @(negedge ck);
        end
        check("mr_in_data", {busy, dq_oe, cs_n, ras_n, cas_n, we_n}, {1'b1, 1'b0, B_NOP});
        reset = 1'b1;
        @(posedge ck);
        @(negedge ck);
        init_seq("mid");
        check("dq_conflicts", 64'(conflicts), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
